// File: rtl/filter_window_gen.sv
// ============================================================================
// Module      : filter_window_gen
// Description : Raster pixel stream to 3x3 window generator (dxi producer).
//               Optional start-of-frame input enabled by FILTER_WINDOW_SOF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module filter_window_gen #(
    parameter int p_data_bw    = 10,
    parameter int p_win_size   = 9,
    parameter int p_img_width  = 640,
    parameter int p_img_height = 480
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    input  logic                 i_dxi_in_valid,
    output logic                 o_dxi_in_ready,
    input  logic [p_data_bw-1:0] i_dxi_in_data,
`ifdef FILTER_WINDOW_SOF_EN
    input  logic                 i_dxi_in_sof,
`endif
    output logic                 o_dxi_out_valid,
    input  logic                 i_dxi_out_ready,
    output logic [p_data_bw-1:0] o_dxi_out_data [p_win_size],
    output logic                 o_dxi_out_last
);

    localparam int c_col_w = $clog2(p_img_width);
    localparam int c_row_w = $clog2(p_img_height);
    localparam logic [c_col_w-1:0] c_col_last = c_col_w'(p_img_width - 1);
    localparam logic [c_row_w-1:0] c_row_last = c_row_w'(p_img_height - 1);
    localparam logic [c_col_w-1:0] c_col_two  = c_col_w'(2);
    localparam logic [c_row_w-1:0] c_row_two  = c_row_w'(2);

    logic [c_col_w-1:0]   r_col;
    logic [c_row_w-1:0]   r_row;
    logic                 r_valid;
    logic                 r_last;
    logic [p_data_bw-1:0] r_win [p_win_size];
    logic [p_data_bw-1:0] r_lb0 [p_img_width];
    logic [p_data_bw-1:0] r_lb1 [p_img_width];

    logic                 w_accept;
    logic                 w_transfer;
    logic                 w_sof;
    logic [c_col_w-1:0]   w_col;
    logic [c_row_w-1:0]   w_row;
    logic [c_col_w-1:0]   w_col_nxt;
    logic [c_row_w-1:0]   w_row_nxt;
    logic [p_data_bw-1:0] w_lb0_rd;
    logic [p_data_bw-1:0] w_lb1_rd;
    logic                 w_win_done;
    logic                 w_frame_end;

    assign o_dxi_in_ready = !r_valid || i_dxi_out_ready;
    assign w_accept       = i_dxi_in_valid && o_dxi_in_ready;
    assign w_transfer     = r_valid && i_dxi_out_ready;

`ifdef FILTER_WINDOW_SOF_EN
    assign w_sof = i_dxi_in_sof;
`else
    assign w_sof = 1'b0;
`endif

    // A start-of-frame pixel is handled exactly as if it arrived at (0, 0).
    assign w_col = w_sof ? '0 : r_col;
    assign w_row = w_sof ? '0 : r_row;

    assign w_lb0_rd    = r_lb0[w_col];
    assign w_lb1_rd    = r_lb1[w_col];
    assign w_win_done  = (w_row >= c_row_two) && (w_col >= c_col_two);
    assign w_frame_end = (w_row == c_row_last) && (w_col == c_col_last);

    always_comb begin
        w_col_nxt = w_col + c_col_w'(1);
        w_row_nxt = w_row;
        if (w_col == c_col_last) begin
            w_col_nxt = '0;
            w_row_nxt = (w_row == c_row_last) ? '0 : w_row + c_row_w'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            r_col <= w_col_nxt;
            r_row <= w_row_nxt;
        end
    end

    // Read-before-write: lb1 content ages into lb0 at the same column.
    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_lb0[w_col] <= w_lb1_rd;
            r_lb1[w_col] <= i_dxi_in_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            for (int k = 0; k < p_win_size; k++) begin
                r_win[k] <= '0;
            end
        end else if (w_accept) begin
            for (int r = 0; r < 3; r++) begin
                r_win[r*3 + 0] <= r_win[r*3 + 1];
                r_win[r*3 + 1] <= r_win[r*3 + 2];
            end
            r_win[2] <= w_lb0_rd;
            r_win[5] <= w_lb1_rd;
            r_win[8] <= i_dxi_in_data;
        end
    end

    // Accept is only possible when the current window is gone or leaving.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else if (w_accept) begin
            r_valid <= w_win_done;
            r_last  <= w_win_done && w_frame_end;
        end else if (w_transfer) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end
    end

    assign o_dxi_out_valid = r_valid;
    assign o_dxi_out_last  = r_last;

    for (genvar k = 0; k < p_win_size; k++) begin : g_out
        assign o_dxi_out_data[k] = r_win[k];
    end

endmodule

`default_nettype wire

// File: tb/tb_filter_window_gen.sv
// ============================================================================
// Module      : tb_filter_window_gen
// Description : Self-checking bench for filter_window_gen (5x4 image).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_filter_window_gen;

    localparam int W   = 5;
    localparam int H   = 4;
    localparam int DBW = 10;
    localparam int WS  = 9;

    typedef struct packed {
        logic                   last;
        logic [WS-1:0][DBW-1:0] px;
    } win_t;

    logic           clk       = 1'b0;
    logic           rstn      = 1'b1;
    logic           in_valid  = 1'b0;
    logic           in_ready;
    logic [DBW-1:0] in_data   = '0;
    logic           sof       = 1'b0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [DBW-1:0] out_data [WS];
    logic           out_last;

    win_t q[$];
    win_t got[$];
    int   img [H][W];
    int   m_row    = 0;
    int   m_col    = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   rand_rdy = 1'b0;

    always #5 clk = ~clk;

    filter_window_gen #(
        .p_data_bw   (DBW),
        .p_win_size  (WS),
        .p_img_width (W),
        .p_img_height(H)
    ) dut (
        .i_clk          (clk),
        .i_rstn         (rstn),
        .i_dxi_in_valid (in_valid),
        .o_dxi_in_ready (in_ready),
        .i_dxi_in_data  (in_data),
`ifdef FILTER_WINDOW_SOF_EN
        .i_dxi_in_sof   (sof),
`endif
        .o_dxi_out_valid(out_valid),
        .i_dxi_out_ready(out_ready),
        .o_dxi_out_data (out_data),
        .o_dxi_out_last (out_last)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic win_t pack_out();
        win_t w;
        w.last = out_last;
        for (int k = 0; k < WS; k++) w.px[k] = out_data[k];
        return w;
    endfunction

    // Window for pixel value 16*row+col, completed at pixel (r, c).
    function automatic win_t exp_win(input int r, input int c);
        win_t w;
        for (int k = 0; k < WS; k++) w.px[k] = DBW'(16 * (r - 2 + k / 3) + (c - 2 + k % 3));
        w.last = (r == H - 1) && (c == W - 1);
        return w;
    endfunction

    task automatic model_accept(input int d, input bit s);
        win_t w;
        if (s) begin
            m_row = 0;
            m_col = 0;
        end
        img[m_row][m_col] = d;
        if (m_row >= 2 && m_col >= 2) begin
            for (int k = 0; k < WS; k++) w.px[k] = DBW'(img[m_row - 2 + k / 3][m_col - 2 + k % 3]);
            w.last = (m_row == H - 1) && (m_col == W - 1);
            q.push_back(w);
        end
        m_col++;
        if (m_col == W) begin
            m_col = 0;
            m_row = (m_row == H - 1) ? 0 : m_row + 1;
        end
    endtask

    // Single compare process: outputs reflect all accepts up to the last posedge.
    always @(negedge clk) begin
        bit s;
        if (!rstn) begin
            check("reset_valid", out_valid, 1'b0);
            check("reset_last", out_last, 1'b0);
            q.delete();
            m_row = 0;
            m_col = 0;
        end else begin
            check("valid", out_valid, q.size() != 0);
            check("in_ready", in_ready, !out_valid || out_ready);
            if (out_valid && q.size() != 0) check("window", pack_out(), q[0]);
            if (out_valid && out_ready) begin
                got.push_back(pack_out());
                if (q.size() != 0) void'(q.pop_front());
            end
            s = 1'b0;
`ifdef FILTER_WINDOW_SOF_EN
            s = sof;
`endif
            if (in_valid && in_ready) model_accept(int'(in_data), s);
        end
    end

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            out_ready = ($urandom_range(0, 1) == 1);
        end
    end

    task automatic send(input int d, input bit s, input int gap_pct);
        bit acc;
        bit ok;
        while ($urandom_range(0, 99) < gap_pct) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = DBW'(d);
        sof      = s;
        ok       = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("send_timeout", ok, 1'b1);
        in_valid = 1'b0;
        sof      = 1'b0;
    endtask

    task automatic send_frame(input int gap_pct, input bit rnd, input bit sof_first, input int stall_at);
        for (int idx = 0; idx < W * H; idx++) begin
            int r = idx / W;
            int c = idx % W;
            send(rnd ? int'($urandom_range(0, 1023)) : 16 * r + c, sof_first && idx == 0, gap_pct);
            if (idx == stall_at) begin
                out_ready = 1'b0;
                in_valid  = 1'b1;
                in_data   = DBW'(16 * ((idx + 1) / W) + (idx + 1) % W);
                for (int n = 0; n < 3; n++) begin
                    @(negedge clk);
                    check("stall_in_ready", in_ready, 1'b0);
                    check("stall_valid", out_valid, 1'b1);
                    check("stall_data", pack_out(), exp_win(r, c));
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
                in_valid  = 1'b0;
            end
        end
    endtask

    task automatic drain();
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic check_frame(input string name, input int base);
        for (int i = 0; i < 6; i++) begin
            if (base + i < got.size()) check(name, got[base + i], exp_win(2 + i / 3, 2 + i % 3));
        end
    endtask

    initial begin
        win_t w_first;
        win_t w_last;
        int   lf [9] = '{0, 1, 2, 16, 17, 18, 32, 33, 34};
        int   ll [9] = '{18, 19, 20, 34, 35, 36, 50, 51, 52};
        for (int k = 0; k < WS; k++) begin
            w_first.px[k] = DBW'(lf[k]);
            w_last.px[k]  = DBW'(ll[k]);
        end
        w_first.last = 1'b0;
        w_last.last  = 1'b1;

        #2 rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_state_valid", out_valid, 1'b0);
        check("rst_state_last", out_last, 1'b0);
        check("rst_state_data", pack_out(), '0);
        check("rst_state_in_ready", in_ready, 1'b1);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // One gap-free frame
        got.delete();
        send_frame(0, 1'b0, 1'b0, -1);
        drain();
        check("frame1_count", got.size(), 6);
        if (got.size() == 6) begin
            check("frame1_first", got[0], w_first);
            check("frame1_last", got[5], w_last);
        end
        check_frame("frame1_win", 0);

        // Two frames back-to-back
        got.delete();
        send_frame(0, 1'b0, 1'b0, -1);
        send_frame(0, 1'b0, 1'b0, -1);
        drain();
        check("b2b_count", got.size(), 12);
        if (got.size() == 12) begin
            check("b2b_second_first", got[6], w_first);
            check("b2b_second_last", got[11], w_last);
        end
        check_frame("b2b_win", 6);

        // Output stall right after the first window of the frame
        got.delete();
        send_frame(0, 1'b0, 1'b0, 2 * W + 2);
        drain();
        check("stall_count", got.size(), 6);
        check_frame("stall_win", 0);

        // Random input gaps
        got.delete();
        send_frame(50, 1'b0, 1'b0, -1);
        drain();
        check("gaps_count", got.size(), 6);
        check_frame("gaps_win", 0);

        // Random data, gaps and downstream backpressure
        got.delete();
        rand_rdy = 1'b1;
        for (int f = 0; f < 3; f++) send_frame(30, 1'b1, 1'b0, -1);
        rand_rdy = 1'b0;
        @(posedge clk);
        #2 out_ready = 1'b1;
        drain();
        check("random_count", got.size(), 18);

        // Reset mid-frame after pixel (2,3)
        for (int idx = 0; idx <= 2 * W + 3; idx++) send(16 * (idx / W) + idx % W, 1'b0, 0);
        rstn = 1'b0;
        #1;
        check("midrst_valid", out_valid, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        got.delete();
        send_frame(0, 1'b0, 1'b0, -1);
        drain();
        check("postrst_count", got.size(), 6);
        check_frame("postrst_win", 0);

`ifdef FILTER_WINDOW_SOF_EN
        got.delete();
        for (int idx = 0; idx < 7; idx++) send(16 * (idx / W) + idx % W, 1'b0, 0);
        drain();
        check("sof_partial_count", got.size(), 0);
        send_frame(0, 1'b0, 1'b1, -1);
        drain();
        check("sof_count", got.size(), 6);
        check_frame("sof_win", 0);
`endif

        check("queue_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
